// File: rtl/aes_mixcol_pkg.sv
// Shared definitions for the AES MixColumns / InvMixColumns engine.
// Holds the GF(2^8) xtime helper, column/polynomial constants, the engine
// state enum and the mode encodings used by the engine and column sub-module.
package aes_mixcol_pkg;

    localparam int unsigned AES_NUM_COLS = 4;
    localparam logic [7:0]  AES_POLY     = 8'h1b;

    localparam logic MIXCOL_FWD = 1'b0;
    localparam logic MIXCOL_INV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } mixcol_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (AES_POLY & {8{x[7]}});
    endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// Combinational transform of one 32-bit AES state column.
// Row r of the column lives at bits [8r+7:8r].
// Optional macro: AES_MIXCOL_INV_EN compiles in the inverse pre-step;
// without it inv_i is ignored and the forward transform is always applied.
// Ports:
//   col_i  - input column
//   inv_i  - 0: MixColumns, 1: InvMixColumns
//   col_o  - transformed column
module aes_mixcol_col
    import aes_mixcol_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = col_i[7:0];
    assign a1 = col_i[15:8];
    assign a2 = col_i[23:16];
    assign a3 = col_i[31:24];

`ifdef AES_MIXCOL_INV_EN
    logic [7:0] u, v;

    // Folding 4*(a0^a2) / 4*(a1^a3) into the input turns the forward
    // {2,3,1,1} network into the inverse {14,11,13,9} one.
    assign u = xtime(xtime(a0 ^ a2));
    assign v = xtime(xtime(a1 ^ a3));

    always_comb begin
        b0 = a0;
        b1 = a1;
        b2 = a2;
        b3 = a3;
        if (inv_i == MIXCOL_INV) begin
            b0 = a0 ^ u;
            b1 = a1 ^ v;
            b2 = a2 ^ u;
            b3 = a3 ^ v;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv_i;

    assign b0 = a0;
    assign b1 = a1;
    assign b2 = a2;
    assign b3 = a3;
`endif

    // o_r = 2*b_r ^ 3*b_{r+1} ^ b_{r+2} ^ b_{r+3}
    assign col_o[7:0]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    assign col_o[15:8]  = xtime(b1) ^ xtime(b2) ^ b2 ^ b3 ^ b0;
    assign col_o[23:16] = xtime(b2) ^ xtime(b3) ^ b3 ^ b0 ^ b1;
    assign col_o[31:24] = xtime(b3) ^ xtime(b0) ^ b0 ^ b1 ^ b2;

endmodule

// File: rtl/aes_mixcol_engine.sv
// Handshaked AES MixColumns / InvMixColumns engine.
// Accepts one 128-bit state, transforms COLS columns per cycle over 4/COLS
// beats, then holds the result until the downstream stage takes it.
// Column k of a state is at [127-32k -: 32].
// Optional macro: AES_MIXCOL_INV_EN enables in_inv; without it every
// transfer computes forward MixColumns.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - input handshake; in_data state, in_inv mode
//   out_valid/out_ready  - output handshake; out_data result
//   busy                 - high while columns are being computed
module aes_mixcol_engine
    import aes_mixcol_pkg::*;
#(
    parameter int unsigned COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS != 1 && COLS != 2 && COLS != 4) begin : g_bad_cols
        $error("aes_mixcol_engine: COLS must be 1, 2 or 4");
    end

    localparam int unsigned NumBeats = AES_NUM_COLS / COLS;
    localparam logic [1:0]  LastBeat = 2'(NumBeats - 1);

    mixcol_state_t state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic [31:0]   src_q [AES_NUM_COLS];
    logic [31:0]   src_d [AES_NUM_COLS];
    logic [31:0]   res_q [AES_NUM_COLS];
    logic [31:0]   res_d [AES_NUM_COLS];
    logic          inv_q;
    logic          accept;

    logic [1:0]    col_idx [COLS];
    logic [31:0]   col_in  [COLS];
    logic [31:0]   col_out [COLS];

    for (genvar j = 0; j < COLS; j++) begin : g_col
        // For COLS=4 the multiplier casts to 0, so lane j always maps to column j.
        assign col_idx[j] = beat_q * 2'(COLS) + 2'(j);
        assign col_in[j]  = src_q[col_idx[j]];

        aes_mixcol_col u_col (
            .col_i (col_in[j]),
            .inv_i (inv_q),
            .col_o (col_out[j])
        );
    end

    // Only OUT makes in_ready depend on out_ready.
    assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q == CALC);
    assign out_data  = {res_q[0], res_q[1], res_q[2], res_q[3]};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        src_d   = src_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: ;
            CALC: begin
                for (int j = 0; j < int'(COLS); j++) begin
                    res_d[col_idx[j]] = col_out[j];
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == LastBeat) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new state can arrive in IDLE or in the same cycle OUT drains.
        if (accept) begin
            for (int k = 0; k < int'(AES_NUM_COLS); k++) begin
                src_d[k] = in_data[127 - 32*k -: 32];
            end
            beat_d  = '0;
            state_d = CALC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            for (int k = 0; k < int'(AES_NUM_COLS); k++) begin
                src_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

`ifdef AES_MIXCOL_INV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= MIXCOL_FWD;
        end else if (accept) begin
            inv_q <= in_inv;
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_q         = MIXCOL_FWD;
`endif

endmodule

// File: doc/aes_mixcol_engine.md
# aes_mixcol_engine

Parametrised, handshaked AES MixColumns / InvMixColumns engine for the round datapath. It accepts one 128-bit state per transfer and processes `COLS` columns per clock over `4/COLS` beats, so area trades against latency. The result is held until the downstream stage takes it. The block replaces the purely combinational four-column mixer in the round pipeline.

## Interface
- `COLS`, 4: columns processed per clock; legal values 1, 2, 4. Any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` and `in_inv` valid.
- `in_ready` output 1: engine can accept a state.
- `in_data` input 128: state; column k at `[127-32k -: 32]`; row r of a column at bits `[8r+7:8r]`.
- `in_inv` input 1: 0 selects MixColumns, 1 selects InvMixColumns.
- `out_valid` output 1: `out_data` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 128: result, same byte layout as `in_data`.
- `busy` output 1: high in CALC.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid&&in_ready`, capture `in_data` into `src_q`, capture `in_inv` into `inv_q`, set `beat_q`=0, go to CALC.
  - CALC: each cycle, columns `beat_q*COLS .. beat_q*COLS+COLS-1` of `src_q` are transformed and written to the same positions of `res_q`; `beat_q` increments. After beat `4/COLS-1`, go to OUT.
  - OUT: `out_valid`=1, `out_data`=`res_q`, both stable until `out_ready`.
    - On `out_valid&&out_ready` with no new `in_valid`: go to IDLE.
    - On `out_valid&&out_ready&&in_valid`: capture the new input and go directly to CALC (`in_ready`=`out_ready` in OUT).
- Forward transform per column, indices mod 4, all arithmetic in GF(2^8) with polynomial 0x11b:
  - `o_r = 2·a_r ^ 3·a_{r+1} ^ a_{r+2} ^ a_{r+3}`.
  - `xtime(x) = {x[6:0],0} ^ (0x1b & {8{x[7]}})`.
- Inverse transform: `o_r = 14·a_r ^ 11·a_{r+1} ^ 13·a_{r+2} ^ 9·a_{r+3}`, implemented as a pre-step then the forward network:
  - `u = xtime(xtime(a0^a2))`, `v = xtime(xtime(a1^a3))`.
  - `a0^=u`, `a2^=u`, `a1^=v`, `a3^=v`.
- Mode is taken from `inv_q` only. Changing `in_inv` mid-operation has no effect.
- `in_data`/`in_inv` are ignored whenever `in_ready`=0.

## Timing
- Reset values: state IDLE; `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0. `src_q`, `res_q`, `beat_q` and `inv_q` are all cleared.
- Latency: accept edge to first cycle with `out_valid`=1 is `4/COLS` cycles (COLS=4: 1; COLS=2: 2; COLS=1: 4).
- Throughput with `out_ready` held high: one state per `4/COLS + 1` cycles.
- Reset asserted in CALC or OUT: the in-flight state is discarded, all outputs return to reset values immediately, and nothing is emitted after reset release.
- `out_valid` never drops without a transfer. `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` only in OUT.

## Configuration
- `AES_MIXCOL_INV_EN` defined: inverse pre-step compiled in, and `in_inv` selects the mode as above.
- `AES_MIXCOL_INV_EN` not defined: pre-step removed. `in_inv` is ignored, `inv_q` is tied to 0, and every transfer computes forward MixColumns.
- The port list is identical in both builds.

## Structure
- Package `aes_mixcol_pkg` holds:
  - `xtime` function;
  - `AES_NUM_COLS`=4 and `AES_POLY`=8'h1b;
  - state enum `mixcol_state_t` {IDLE, CALC, OUT};
  - mode constants `MIXCOL_FWD`=0, `MIXCOL_INV`=1.
- Sub-module `aes_mixcol_col` is a purely combinational single 32-bit column transform with an `inv` input. The inverse pre-step inside it is guarded by the macro. The engine instantiates `COLS` copies, with the column select muxed by `beat_q`.

## Test plan
- Forward, COLS=4: column word 32'h455313db → 32'hbca14d8e; column word 32'h5c220af2 → 32'h9d58dc9f. `out_valid` is high 1 cycle after accept.
- Inverse, COLS=1: column 32'hbca14d8e → 32'h455313db; column 32'hc6c6c6c6 → 32'hc6c6c6c6. `out_valid` rises exactly 4 cycles after accept; `busy` is high for 4 cycles.
- Backpressure, COLS=2: hold `out_ready`=0 for 5 cycles → `out_valid` stays high and `out_data` stays constant; `in_ready`=0 throughout.
- Back-to-back: `in_valid` held high with 4 random states, `out_ready`=1 → 4 results in order matching a software model, each accepted in the same cycle as the previous output transfer.
- Reset in CALC, COLS=1, asserted at beat 2 → `out_valid`=0 and `in_ready`=1 immediately. The next state completes correctly.
- Build without `AES_MIXCOL_INV_EN`, `in_inv`=1, input 32'h455313db in every column → 32'hbca14d8e in every column.
